// File: rtl/pp_row_gen.sv
// pp_row_gen: row-serial partial-product generator.
// Captures one operand pair (a, b) and streams rows a & {WIDTH{b[i]}},
// one per accepted beat, tagged with the row index and a last flag.
// With SKIP_ZERO=1 only rows whose multiplier bit is set are emitted;
// an all-zero multiplier still produces one (zero) row so the consumer
// always sees a terminating beat.
module pp_row_gen #(
  parameter int WIDTH     = 53,
  parameter int SKIP_ZERO = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_row,
  output logic [$clog2(WIDTH)-1:0]   out_idx,
  output logic                       out_last,
  output logic                       busy
);

  localparam int IDXW = $clog2(WIDTH);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t              state;
  logic [WIDTH-1:0]    a_r;
  logic [WIDTH-1:0]    b_r;
  logic [IDXW-1:0]     idx;

  logic [WIDTH-1:0]    above;      // multiplier bits strictly above idx
  logic                last_beat;
  logic [IDXW-1:0]     next_idx;
  logic [IDXW-1:0]     first_idx;
  logic                capture;
  logic                xfer;

  // Lowest set bit of v, 0 when v is all zero.
  function automatic logic [IDXW-1:0] low_set(input logic [WIDTH-1:0] v);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) r = IDXW'(i);
    end
    return r;
  endfunction

  // Mask the captured multiplier to the bits above the current row.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_above
      assign above[gi] = b_r[gi] & (IDXW'(gi) > idx);
    end
  endgenerate

  // Sequencing decisions derived purely from registered state.
  always_comb begin
    last_beat = 1'b0;
    next_idx  = '0;
    first_idx = '0;
    if (SKIP_ZERO != 0) begin
      last_beat = (above == '0);
      next_idx  = low_set(above);
      first_idx = low_set(b);
    end else begin
      last_beat = (idx == IDXW'(WIDTH - 1));
      next_idx  = idx + 1'b1;
      first_idx = '0;
    end
  end

  // Outputs are functions of registers only; in_ready also looks at out_ready
  // so a new pair can be taken on the cycle the last row drains.
  assign busy      = (state == EMIT);
  assign out_valid = busy;
  assign out_idx   = idx;
  assign out_last  = busy & last_beat;
  assign out_row   = busy ? (a_r & {WIDTH{b_r[idx]}}) : '0;
  assign in_ready  = (state == IDLE) | (busy & last_beat & out_ready);
  assign capture   = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;

  // State machine: capture a pair, step through its rows, chain the next pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      a_r   <= '0;
      b_r   <= '0;
    end else if (capture) begin
      a_r   <= a;
      b_r   <= b;
      idx   <= first_idx;
      state <= EMIT;
    end else if (xfer) begin
      if (last_beat) begin
        state <= IDLE;
      end else begin
        idx <= next_idx;
      end
    end
  end

endmodule

// File: tb/tb_pp_row_gen.sv
// Directed bench for pp_row_gen: three instances cover WIDTH=4 with and
// without zero-row skipping, plus the default 53-bit width with skipping.
module tb_pp_row_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // WIDTH=4, SKIP_ZERO=0
  logic       iv0, ir0, ov0, or0, ol0, bz0;
  logic [3:0] a0, b0, row0;
  logic [1:0] idx0;
  // WIDTH=4, SKIP_ZERO=1
  logic       iv1, ir1, ov1, or1, ol1, bz1;
  logic [3:0] a1, b1, row1;
  logic [1:0] idx1;
  // WIDTH=53, SKIP_ZERO=1
  logic        iv2, ir2, ov2, or2, ol2, bz2;
  logic [52:0] a2, b2, row2;
  logic [5:0]  idx2;

  int n_vec = 0;
  int n_err = 0;

  pp_row_gen #(.WIDTH(4), .SKIP_ZERO(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .out_valid(ov0), .out_ready(or0), .out_row(row0), .out_idx(idx0),
    .out_last(ol0), .busy(bz0));

  pp_row_gen #(.WIDTH(4), .SKIP_ZERO(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1), .out_row(row1), .out_idx(idx1),
    .out_last(ol1), .busy(bz1));

  pp_row_gen #(.WIDTH(53), .SKIP_ZERO(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(or2), .out_row(row2), .out_idx(idx2),
    .out_last(ol2), .busy(bz2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat0(input string tag, input logic [3:0] er, input int ei,
                       input logic el, input logic eir);
    chk({tag, "_valid"}, 64'(ov0), 64'(1'b1));
    chk({tag, "_row"}, 64'(row0), 64'(er));
    chk({tag, "_idx"}, 64'(idx0), 64'(ei));
    chk({tag, "_last"}, 64'(ol0), 64'(el));
    chk({tag, "_inrdy"}, 64'(ir0), 64'(eir));
    $display("dut0 %s: idx=%0d row=%b last=%b", tag, idx0, row0, ol0);
  endtask

  task automatic beat1(input string tag, input logic [3:0] er, input int ei,
                       input logic el, input logic eir);
    chk({tag, "_valid"}, 64'(ov1), 64'(1'b1));
    chk({tag, "_row"}, 64'(row1), 64'(er));
    chk({tag, "_idx"}, 64'(idx1), 64'(ei));
    chk({tag, "_last"}, 64'(ol1), 64'(el));
    chk({tag, "_inrdy"}, 64'(ir1), 64'(eir));
    $display("dut1 %s: idx=%0d row=%b last=%b", tag, idx1, row1, ol1);
  endtask

  task automatic idle0(input string tag);
    chk({tag, "_valid"}, 64'(ov0), 64'(1'b0));
    chk({tag, "_busy"}, 64'(bz0), 64'(1'b0));
    chk({tag, "_inrdy"}, 64'(ir0), 64'(1'b1));
    $display("dut0 %s: idle", tag);
  endtask

  task automatic idle1(input string tag);
    chk({tag, "_valid"}, 64'(ov1), 64'(1'b0));
    chk({tag, "_busy"}, 64'(bz1), 64'(1'b0));
    chk({tag, "_inrdy"}, 64'(ir1), 64'(1'b1));
    $display("dut1 %s: idle", tag);
  endtask

  initial begin
    rst = 1'b1;
    iv0 = 0; a0 = '0; b0 = '0; or0 = 1;
    iv1 = 0; a1 = '0; b1 = '0; or1 = 1;
    iv2 = 0; a2 = '0; b2 = '0; or2 = 1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state of every instance
    idle0("rst0");
    chk("rst0_row", 64'(row0), 64'd0);
    chk("rst0_idx", 64'(idx0), 64'd0);
    chk("rst0_last", 64'(ol0), 64'd0);
    idle1("rst1");
    chk("rst1_row", 64'(row1), 64'd0);
    chk("rst2_valid", 64'(ov2), 64'd0);
    chk("rst2_inrdy", 64'(ir2), 64'd1);
    chk("rst2_busy", 64'(bz2), 64'd0);

    // Full row sweep, a=1011 b=0101
    a0 = 4'b1011; b0 = 4'b0101; iv0 = 1;
    tick(); iv0 = 0;
    beat0("t1_b0", 4'b1011, 0, 0, 0);
    tick(); beat0("t1_b1", 4'b0000, 1, 0, 0);
    tick(); beat0("t1_b2", 4'b1011, 2, 0, 0);
    tick(); beat0("t1_b3", 4'b0000, 3, 1, 1);
    tick(); idle0("t1_end");

    // Backpressure held at idx1 for three cycles
    iv0 = 1;
    tick(); iv0 = 0;
    beat0("t3_b0", 4'b1011, 0, 0, 0);
    tick(); beat0("t3_b1", 4'b0000, 1, 0, 0);
    or0 = 0;
    for (int k = 0; k < 3; k++) begin
      tick(); beat0("t3_hold", 4'b0000, 1, 0, 0);
    end
    or0 = 1;
    tick(); beat0("t3_b2", 4'b1011, 2, 0, 0);
    tick(); beat0("t3_b3", 4'b0000, 3, 1, 1);
    tick(); idle0("t3_end");

    // Back-to-back pairs with no bubble
    iv0 = 1;
    tick(); iv0 = 0;
    beat0("t4_b0", 4'b1011, 0, 0, 0);
    tick(); tick(); tick();
    beat0("t4_b3", 4'b0000, 3, 1, 1);
    a0 = 4'b1111; b0 = 4'b1000; iv0 = 1;
    #1;
    chk("t4_inrdy_last", 64'(ir0), 64'd1);
    tick(); iv0 = 0;
    beat0("t4_n0", 4'b0000, 0, 0, 0);
    chk("t4_n0_busy", 64'(bz0), 64'd1);
    tick(); beat0("t4_n1", 4'b0000, 1, 0, 0);
    tick(); beat0("t4_n2", 4'b0000, 2, 0, 0);
    tick(); beat0("t4_n3", 4'b1111, 3, 1, 1);
    tick(); idle0("t4_end");

    // Reset in the middle of a pair
    a0 = 4'b1011; b0 = 4'b0101; iv0 = 1;
    tick(); iv0 = 0;
    tick(); tick();
    beat0("t5_pre", 4'b1011, 2, 0, 0);
    rst = 1;
    tick(); rst = 0;
    idle0("t5_rst");
    chk("t5_idx", 64'(idx0), 64'd0);
    chk("t5_row", 64'(row0), 64'd0);
    tick(); idle0("t5_nostale");
    a0 = 4'b0110; b0 = 4'b0011; iv0 = 1;
    tick(); iv0 = 0;
    beat0("t5_b0", 4'b0110, 0, 0, 0);
    tick(); beat0("t5_b1", 4'b0110, 1, 0, 0);
    tick(); beat0("t5_b2", 4'b0000, 2, 0, 0);
    tick(); beat0("t5_b3", 4'b0000, 3, 1, 1);
    tick(); idle0("t5_end");

    // Zero-row skipping
    a1 = 4'b1011; b1 = 4'b0101; iv1 = 1;
    tick(); iv1 = 0;
    beat1("t2_b0", 4'b1011, 0, 0, 0);
    tick(); beat1("t2_b1", 4'b1011, 2, 1, 1);
    tick(); idle1("t2_end");
    b1 = 4'b0000; iv1 = 1;
    tick(); iv1 = 0;
    beat1("t2_zero", 4'b0000, 0, 1, 1);
    tick(); idle1("t2_zend");
    a1 = 4'b0111; b1 = 4'b1010; iv1 = 1;
    tick(); iv1 = 0;
    beat1("t2_c0", 4'b0111, 1, 0, 0);
    tick(); beat1("t2_c1", 4'b0111, 3, 1, 1);
    tick(); idle1("t2_cend");

    // Default width, single top row
    a2 = '1; b2 = 53'd1 << 52; iv2 = 1;
    tick(); iv2 = 0;
    chk("t6_valid", 64'(ov2), 64'd1);
    chk("t6_idx", 64'(idx2), 64'd52);
    chk("t6_row", 64'(row2), 64'h1F_FFFF_FFFF_FFFF);
    chk("t6_last", 64'(ol2), 64'd1);
    chk("t6_inrdy", 64'(ir2), 64'd1);
    $display("dut2 t6: idx=%0d row=%h last=%b", idx2, row2, ol2);
    tick();
    chk("t6_end_valid", 64'(ov2), 64'd0);
    chk("t6_end_busy", 64'(bz2), 64'd0);
    $display("dut2 t6_end: idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
